// File: rtl/vga_timing_gen.sv
// Raster timing generator: scan counters, visible-area flag, PIPE_DELAY-aligned sync,
// line/frame strobes and a free-running completed-frame counter.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [9:0]  hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic        blank_q, blank_d;
  logic        hs_raw_q, hs_raw_d;
  logic        vs_raw_q, vs_raw_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q, frame_count_d;

  // Status flags decode the next counter value so they land on the same edge as DrawX/DrawY.
  always_comb begin
    hc_d          = hc_q + 10'd1;
    vc_d          = vc_q;
    frame_count_d = frame_count_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      if (vc_q == V_LAST) begin
        vc_d          = '0;
        frame_count_d = frame_count_q + 16'd1;
      end else begin
        vc_d = vc_q + 10'd1;
      end
    end
    blank_d       = (32'(hc_d) < H_VISIBLE) && (32'(vc_d) < V_VISIBLE);
    hs_raw_d      = ((32'(hc_d) >= HS_START) && (32'(hc_d) < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_raw_d      = ((32'(vc_d) >= VS_START) && (32'(vc_d) < VS_END)) ? SYNC_POL : ~SYNC_POL;
    line_start_d  = (hc_d == '0);
    frame_start_d = (hc_d == '0) && (vc_d == '0);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc_q          <= '0;
      vc_q          <= '0;
      blank_q       <= 1'b0;
      hs_raw_q      <= ~SYNC_POL;
      vs_raw_q      <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      blank_q       <= blank_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

  // Sync delay line; bit 0 of each chain is the undelayed sync, bit PIPE_DELAY the output.
  if (PIPE_DELAY == 0) begin : g_nopipe
    assign hs = hs_raw_q;
    assign vs = vs_raw_q;
  end else begin : g_pipe
    logic [PIPE_DELAY-1:0] hs_pipe_q;
    logic [PIPE_DELAY-1:0] vs_pipe_q;
    logic [PIPE_DELAY:0]   hs_chain;
    logic [PIPE_DELAY:0]   vs_chain;

    assign hs_chain = {hs_pipe_q, hs_raw_q};
    assign vs_chain = {vs_pipe_q, vs_raw_q};

    always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
        hs_pipe_q <= {PIPE_DELAY{~SYNC_POL}};
        vs_pipe_q <= {PIPE_DELAY{~SYNC_POL}};
      end else begin
        hs_pipe_q <= hs_chain[PIPE_DELAY-1:0];
        vs_pipe_q <= vs_chain[PIPE_DELAY-1:0];
      end
    end

    assign hs = hs_chain[PIPE_DELAY];
    assign vs = vs_chain[PIPE_DELAY];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x525 timing, a short-frame variant for vsync/frame checks,
// and a tiny 7x6 raster for zero-delay sync and frame counter wrap.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic        rst_d, rst_m, rst_s;
  logic [9:0]  x_d, y_d, x_m, y_m, x_s, y_s;
  logic        bl_d, hs_d, vs_d, ls_d, fs_d;
  logic        bl_m, hs_m, vs_m, ls_m, fs_m;
  logic        bl_s, hs_s, vs_s, ls_s, fs_s;
  logic [15:0] fc_d, fc_m, fc_s;

  vga_timing_gen u_def (
    .vga_clk(clk), .reset(rst_d), .DrawX(x_d), .DrawY(y_d), .blank(bl_d), .hs(hs_d), .vs(vs_d),
    .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d)
  );

  vga_timing_gen #(.V_VISIBLE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_mid (
    .vga_clk(clk), .reset(rst_m), .DrawX(x_m), .DrawY(y_m), .blank(bl_m), .hs(hs_m), .vs(vs_m),
    .line_start(ls_m), .frame_start(fs_m), .frame_count(fc_m)
  );

  vga_timing_gen #(.H_VISIBLE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                   .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE_DELAY(0)) u_small (
    .vga_clk(clk), .reset(rst_s), .DrawX(x_s), .DrawY(y_s), .blank(bl_s), .hs(hs_s), .vs(vs_s),
    .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
  );

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if ({x_d, y_d, bl_d, hs_d, vs_d, ls_d, fs_d, fc_d} !==
          {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0})
        $display("FAIL reset_state: got x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, expected 0 0 0 1 1 0 0 0",
                 x_d, y_d, bl_d, hs_d, vs_d, ls_d, fs_d, fc_d);
      else n_pass++;
    end
    rst_d = 1'b0;
    @(negedge clk);
    n_total++;
    if (x_d !== 10'd1 || y_d !== 10'd0 || bl_d !== 1'b1 || ls_d !== 1'b0 || fs_d !== 1'b0)
      $display("FAIL first_edge: got x=%0d y=%0d blank=%b ls=%b fs=%b, expected x=1 y=0 blank=1 ls=0 fs=0",
               x_d, y_d, bl_d, ls_d, fs_d);
    else n_pass++;
  endtask

  task automatic test_line();
    int k = 1, first = -1, second = -1, bl = 0, hl = 0, fy = -1;
    while (second < 0 && k < 2000) begin
      @(negedge clk);
      k++;
      if (ls_d) begin
        if (first < 0) begin first = k; fy = int'(y_d); end
        else second = k;
      end
      if (first >= 0 && second < 0) begin
        if (bl_d) bl++;
        if (!hs_d) hl++;
        if (x_d == 10'd639) begin
          n_total++;
          if (bl_d !== 1'b1) $display("FAIL blank_x639: got %b expected 1", bl_d); else n_pass++;
        end
        if (x_d == 10'd640) begin
          n_total++;
          if (bl_d !== 1'b0) $display("FAIL blank_x640: got %b expected 0", bl_d); else n_pass++;
        end
        if (x_d == 10'd657) begin
          n_total++;
          if (hs_d !== 1'b1) $display("FAIL hs_x657: got %b expected 1", hs_d); else n_pass++;
        end
        if (x_d == 10'd658) begin
          n_total++;
          if (hs_d !== 1'b0) $display("FAIL hs_x658: got %b expected 0", hs_d); else n_pass++;
        end
        if (x_d == 10'd753) begin
          n_total++;
          if (hs_d !== 1'b0) $display("FAIL hs_x753: got %b expected 0", hs_d); else n_pass++;
        end
        if (x_d == 10'd754) begin
          n_total++;
          if (hs_d !== 1'b1) $display("FAIL hs_x754: got %b expected 1", hs_d); else n_pass++;
        end
      end
    end
    n_total++;
    if (first !== 800 || fy !== 1) $display("FAIL first_line_start: got cycle %0d row %0d expected cycle 800 row 1", first, fy);
    else n_pass++;
    n_total++;
    if (second - first !== 800) $display("FAIL line_period: got %0d expected 800", second - first); else n_pass++;
    n_total++;
    if (bl !== 640) $display("FAIL blank_per_line: got %0d expected 640", bl); else n_pass++;
    n_total++;
    if (hl !== 96) $display("FAIL hs_width: got %0d expected 96", hl); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k = 0, lows = 0;
    while (x_d != 10'd700 && k < 1000) begin @(negedge clk); k++; end
    n_total++;
    if (x_d !== 10'd700 || hs_d !== 1'b0) $display("FAIL hs_before_reset: got x=%0d hs=%b expected x=700 hs=0", x_d, hs_d);
    else n_pass++;
    rst_d = 1'b1;
    #1;
    n_total++;
    if ({x_d, y_d, bl_d, hs_d, vs_d, ls_d, fs_d} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0})
      $display("FAIL async_reset: got x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b expected 0 0 0 1 1 0 0",
               x_d, y_d, bl_d, hs_d, vs_d, ls_d, fs_d);
    else n_pass++;
    @(negedge clk);
    rst_d = 1'b0;
    k = 0;
    while (!ls_d && k < 1000) begin
      @(negedge clk);
      k++;
      if (k < 658 && !hs_d) lows++;
    end
    n_total++;
    if (k !== 800) $display("FAIL line_start_after_reset: got %0d cycles expected 800", k); else n_pass++;
    n_total++;
    if (lows !== 0) $display("FAIL hs_remnant: got %0d low cycles expected 0", lows); else n_pass++;
  endtask

  task automatic test_vsync();
    int first = -1, last = -1, lows = 0, bl = 0, fs_early = 0, fx = -1, fy = -1;
    n_total++;
    if (vs_m !== 1'b1 || fc_m !== 16'd0) $display("FAIL mid_reset: got vs=%b fc=%0d expected vs=1 fc=0", vs_m, fc_m);
    else n_pass++;
    @(negedge clk);
    rst_m = 1'b0;
    for (int k = 1; k <= 8000; k++) begin
      @(negedge clk);
      if (!vs_m) begin
        lows++;
        if (first < 0) begin first = k; fx = int'(x_m); fy = int'(y_m); end
        last = k;
      end
      if (bl_m) bl++;
      if (fs_m && k < 8000) fs_early++;
    end
    n_total++;
    if (fx !== 2 || fy !== 6) $display("FAIL vs_start: got x=%0d y=%0d expected x=2 y=6", fx, fy); else n_pass++;
    n_total++;
    if (lows !== 1600) $display("FAIL vs_width: got %0d expected 1600", lows); else n_pass++;
    n_total++;
    if (last - first + 1 !== 1600) $display("FAIL vs_contiguous: got span %0d expected 1600", last - first + 1); else n_pass++;
    n_total++;
    if (bl !== 2560) $display("FAIL blank_per_frame: got %0d expected 2560", bl); else n_pass++;
    n_total++;
    if (fs_early !== 0) $display("FAIL early_frame_start: got %0d pulses expected 0", fs_early); else n_pass++;
    n_total++;
    if (fs_m !== 1'b1 || fc_m !== 16'd1 || x_m !== 10'd0 || y_m !== 10'd0)
      $display("FAIL first_frame_start: got fs=%b fc=%0d x=%0d y=%0d expected 1 1 0 0", fs_m, fc_m, x_m, y_m);
    else n_pass++;
  endtask

  task automatic test_frames();
    int k = 0, lastp = 0, np = 0;
    logic [15:0] prev_fc;
    prev_fc = fc_m;
    while (np < 2 && k < 20000) begin
      @(negedge clk);
      k++;
      if (fs_m) begin
        np++;
        n_total++;
        if (k - lastp !== 8000) $display("FAIL frame_period: got %0d expected 8000", k - lastp); else n_pass++;
        n_total++;
        if (fc_m !== 16'(np + 1) || prev_fc !== 16'(np) || x_m !== 10'd0 || y_m !== 10'd0)
          $display("FAIL frame_count_step: got %0d->%0d at x=%0d y=%0d expected %0d->%0d at 0 0",
                   prev_fc, fc_m, x_m, y_m, np, np + 1);
        else n_pass++;
        lastp = k;
      end
      prev_fc = fc_m;
    end
    n_total++;
    if (np !== 2) $display("FAIL frame_timeout: got %0d pulses expected 2", np); else n_pass++;
  endtask

  task automatic test_small();
    int ls1 = -1, ls2 = -1, fs1 = -1, fsn = 0, hs_err = 0, vs_err = 0, bl_err = 0, k, np;
    @(negedge clk);
    rst_s = 1'b0;
    for (k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (hs_s !== ((x_s == 10'd5) ? 1'b0 : 1'b1)) hs_err++;
      if (vs_s !== ((y_s == 10'd4) ? 1'b0 : 1'b1)) vs_err++;
      if (bl_s !== ((x_s < 10'd4) && (y_s < 10'd3))) bl_err++;
      if (ls_s) begin if (ls1 < 0) ls1 = k; else if (ls2 < 0) ls2 = k; end
      if (fs_s) begin fsn++; fs1 = k; end
    end
    n_total++;
    if (ls1 !== 7 || ls2 !== 14) $display("FAIL small_line_period: got %0d,%0d expected 7,14", ls1, ls2); else n_pass++;
    n_total++;
    if (fs1 !== 42 || fsn !== 1) $display("FAIL small_frame_period: got cycle %0d count %0d expected 42 1", fs1, fsn); else n_pass++;
    n_total++;
    if (fc_s !== 16'd1) $display("FAIL small_fc: got %0d expected 1", fc_s); else n_pass++;
    n_total++;
    if (hs_err !== 0) $display("FAIL small_hs: got %0d bad cycles expected 0", hs_err); else n_pass++;
    n_total++;
    if (vs_err !== 0) $display("FAIL small_vs: got %0d bad cycles expected 0", vs_err); else n_pass++;
    n_total++;
    if (bl_err !== 0) $display("FAIL small_blank: got %0d bad cycles expected 0", bl_err); else n_pass++;
    @(negedge clk);
    k = 43;
    force u_small.frame_count_q = 16'hFFFE;
    #1;
    release u_small.frame_count_q;
    np = 0;
    while (np < 2 && k < 300) begin
      @(negedge clk);
      k++;
      if (fs_s) begin
        np++;
        if (np == 1) begin
          n_total++;
          if (fc_s !== 16'hFFFF || k !== 84) $display("FAIL fc_to_ffff: got %h at cycle %0d expected ffff at 84", fc_s, k);
          else n_pass++;
        end else begin
          n_total++;
          if (fc_s !== 16'h0000 || k !== 126 || x_s !== 10'd0 || y_s !== 10'd0)
            $display("FAIL fc_wrap: got %h at cycle %0d x=%0d y=%0d expected 0000 at 126 x=0 y=0", fc_s, k, x_s, y_s);
          else n_pass++;
        end
      end
    end
    n_total++;
    if (np !== 2) $display("FAIL small_timeout: got %0d pulses expected 2", np); else n_pass++;
  endtask

  initial begin
    rst_d = 1'b1;
    rst_m = 1'b1;
    rst_s = 1'b1;
    test_reset();
    test_line();
    test_reset_mid();
    test_vsync();
    test_frames();
    test_small();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
